// File: rtl/encode_pkg.sv
// Shared constants and state encoding for the 16-to-4 request encoder.
package encode_pkg;

    localparam int N_REQ = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot16(input logic [3:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_sel_16.sv
// Combinational priority select: first set bit scanning upward from start, wrapping at 15.
module prio_sel_16 (
    input  logic [15:0] vec,
    input  logic [3:0]  start,
    output logic [3:0]  idx,
    output logic        found
);

    logic [31:0] dbl;
    logic [15:0] rot;
    logic [3:0]  off;

    always_comb begin
        // rotate so that bit 'start' lands at position 0
        dbl = {vec, vec} >> start;
        rot = dbl[15:0];
        off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) off = 4'(i);
        end
        idx   = start + off;
        found = |vec;
    end

endmodule

// File: rtl/encode_16_4.sv
// Pending-request encoder: captures request bits, presents one index at a time with valid/ready.
module encode_16_4
    import encode_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        req_en,
    output logic [3:0]  addr,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        overflow
);

    state_t      state;
    state_t      state_nxt;
    logic        fire;
    logic [15:0] clr;
    logic [15:0] pend_nxt;
    logic        hit;
    logic [3:0]  last;
    logic [3:0]  start;
    logic [3:0]  sel_idx;
    logic        sel_found;
    logic        load;

    assign fire     = valid & ready;
    assign clr      = fire ? onehot16(addr) : '0;
    assign pend_nxt = (pending & ~clr) | (req_en ? req : '0);
    assign hit      = req_en & (|(req & pending & ~clr));

    // on a fire the granted index becomes the new 'last', so scan from addr+1
    assign start = (ROUND_ROBIN != 0) ? (fire ? addr + 4'd1 : last + 4'd1) : 4'd0;

    prio_sel_16 u_sel (
        .vec   (pend_nxt),
        .start (start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign load = sel_found & ((state == IDLE) | fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pend_nxt)          state_nxt = HOLD;
            HOLD:    if (fire && !(|pend_nxt)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            addr     <= 4'd0;
            overflow <= 1'b0;
            last     <= 4'd15;
        end else begin
            pending  <= pend_nxt;
            overflow <= hit;
            if (load) addr <= sel_idx;
            if (fire) last <= addr;
        end
    end

endmodule

// File: tb/tb_encode_16_4.sv
// Directed bench for encode_16_4: one fixed-priority and one rotating-priority instance.
module tb_encode_16_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] req_f = '0;
    logic        req_en_f = 1'b0;
    logic        ready_f = 1'b0;
    logic [3:0]  addr_f;
    logic        valid_f;
    logic [15:0] pending_f;
    logic        overflow_f;

    logic [15:0] req_r = '0;
    logic        req_en_r = 1'b0;
    logic        ready_r = 1'b0;
    logic [3:0]  addr_r;
    logic        valid_r;
    logic [15:0] pending_r;
    logic        overflow_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encode_16_4 #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req_f), .req_en(req_en_f),
        .addr(addr_f), .valid(valid_f), .ready(ready_f),
        .pending(pending_f), .overflow(overflow_f)
    );

    encode_16_4 #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .req_en(req_en_r),
        .addr(addr_r), .valid(valid_r), .ready(ready_r),
        .pending(pending_r), .overflow(overflow_r)
    );

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check_val("rst_pending_f", pending_f, 16'h0000);
        check_val("rst_valid_f", {15'd0, valid_f}, 16'd0);
        check_val("rst_addr_f", {12'd0, addr_f}, 16'd0);
        check_val("rst_ovf_f", {15'd0, overflow_f}, 16'd0);
        check_val("rst_valid_r", {15'd0, valid_r}, 16'd0);
        #10 rst_n = 1'b1;

        // ready while idle does nothing
        ready_f = 1'b1;
        step();
        check_val("idle_ready_valid", {15'd0, valid_f}, 16'd0);
        check_val("idle_ready_pend", pending_f, 16'h0000);

        // fixed-priority drain
        req_f = 16'h8421; req_en_f = 1'b1;
        step();
        req_f = '0; req_en_f = 1'b0;
        check_val("drain_addr0", {12'd0, addr_f}, 16'd0);
        check_val("drain_valid0", {15'd0, valid_f}, 16'd1);
        check_val("drain_pend0", pending_f, 16'h8421);
        step();
        check_val("drain_addr5", {12'd0, addr_f}, 16'd5);
        check_val("drain_pend5", pending_f, 16'h8420);
        step();
        check_val("drain_addr10", {12'd0, addr_f}, 16'd10);
        step();
        check_val("drain_addr15", {12'd0, addr_f}, 16'd15);
        check_val("drain_pend15", pending_f, 16'h8000);
        step();
        check_val("drain_valid_end", {15'd0, valid_f}, 16'd0);
        check_val("drain_pend_end", pending_f, 16'h0000);

        // hold stability under back-pressure
        ready_f = 1'b0;
        req_f = 16'h0100; req_en_f = 1'b1;
        step();
        req_en_f = 1'b0;
        check_val("hold_addr8", {12'd0, addr_f}, 16'd8);
        check_val("hold_valid", {15'd0, valid_f}, 16'd1);
        req_f = 16'h0001; req_en_f = 1'b1;
        step();
        req_en_f = 1'b0;
        check_val("hold_addr8_b", {12'd0, addr_f}, 16'd8);
        check_val("hold_pend", pending_f, 16'h0101);
        step();
        check_val("hold_addr8_c", {12'd0, addr_f}, 16'd8);
        ready_f = 1'b1;
        step();
        check_val("hold_next_addr0", {12'd0, addr_f}, 16'd0);
        check_val("hold_next_valid", {15'd0, valid_f}, 16'd1);
        check_val("hold_next_pend", pending_f, 16'h0001);
        step();
        check_val("hold_end_valid", {15'd0, valid_f}, 16'd0);
        ready_f = 1'b0;

        // consume + re-request, and duplicate request overflow
        req_f = 16'h0008; req_en_f = 1'b1;
        step();
        req_en_f = 1'b0;
        check_val("sim_addr3", {12'd0, addr_f}, 16'd3);
        ready_f = 1'b1; req_f = 16'h0008; req_en_f = 1'b1;
        step();
        check_val("sim_rereq_pend", pending_f, 16'h0008);
        check_val("sim_rereq_ovf", {15'd0, overflow_f}, 16'd0);
        check_val("sim_rereq_valid", {15'd0, valid_f}, 16'd1);
        check_val("sim_rereq_addr", {12'd0, addr_f}, 16'd3);
        ready_f = 1'b0; req_f = 16'h0010; req_en_f = 1'b1;
        step();
        check_val("sim_new4_pend", pending_f, 16'h0018);
        check_val("sim_new4_ovf", {15'd0, overflow_f}, 16'd0);
        step();
        check_val("sim_dup4_ovf", {15'd0, overflow_f}, 16'd1);
        check_val("sim_dup4_pend", pending_f, 16'h0018);
        req_en_f = 1'b0; req_f = '0;
        step();
        check_val("sim_ovf_pulse_end", {15'd0, overflow_f}, 16'd0);
        ready_f = 1'b1;
        step();
        check_val("sim_addr4", {12'd0, addr_f}, 16'd4);
        check_val("sim_pend4", pending_f, 16'h0010);
        step();
        check_val("sim_end_valid", {15'd0, valid_f}, 16'd0);
        ready_f = 1'b0;

        // asynchronous reset in the middle of HOLD
        req_f = 16'h00F0; req_en_f = 1'b1;
        step();
        req_en_f = 1'b0; req_f = '0;
        check_val("pre_rst_addr", {12'd0, addr_f}, 16'd4);
        check_val("pre_rst_pend", pending_f, 16'h00F0);
        #3 rst_n = 1'b0;
        #1;
        check_val("mid_rst_pend", pending_f, 16'h0000);
        check_val("mid_rst_valid", {15'd0, valid_f}, 16'd0);
        check_val("mid_rst_addr", {12'd0, addr_f}, 16'd0);
        #2 rst_n = 1'b1;
        step();
        check_val("post_rst_valid", {15'd0, valid_f}, 16'd0);
        check_val("post_rst_pend", pending_f, 16'h0000);
        step();
        check_val("post_rst_valid2", {15'd0, valid_f}, 16'd0);

        // rotating: single bit 14 granted, then wrap 15 -> 0
        ready_r = 1'b1; req_r = 16'h4000; req_en_r = 1'b1;
        step();
        req_en_r = 1'b0; req_r = '0;
        check_val("rr_single14", {12'd0, addr_r}, 16'd14);
        check_val("rr_single_valid", {15'd0, valid_r}, 16'd1);
        step();
        check_val("rr_single_done", {15'd0, valid_r}, 16'd0);
        ready_r = 1'b0; req_r = 16'h8001; req_en_r = 1'b1;
        step();
        req_en_r = 1'b0; req_r = '0;
        check_val("rr_wrap15", {12'd0, addr_r}, 16'd15);
        check_val("rr_wrap_pend", pending_r, 16'h8001);
        ready_r = 1'b1;
        step();
        check_val("rr_wrap0", {12'd0, addr_r}, 16'd0);
        check_val("rr_wrap0_valid", {15'd0, valid_r}, 16'd1);
        step();
        check_val("rr_wrap_done", {15'd0, valid_r}, 16'd0);

        // rotating fairness with continuous re-request of bits 2 and 9
        req_r = 16'h0204; req_en_r = 1'b1;
        step();
        check_val("rr_fair_2a", {12'd0, addr_r}, 16'd2);
        step();
        check_val("rr_fair_9a", {12'd0, addr_r}, 16'd9);
        step();
        check_val("rr_fair_2b", {12'd0, addr_r}, 16'd2);
        step();
        check_val("rr_fair_9b", {12'd0, addr_r}, 16'd9);
        req_en_r = 1'b0; req_r = '0;
        step();
        check_val("rr_fair_tail", {12'd0, addr_r}, 16'd2);
        step();
        check_val("rr_fair_end_valid", {15'd0, valid_r}, 16'd0);
        check_val("rr_fair_end_pend", pending_r, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
